// File: rtl/int18_pkg.sv
// Shared definitions for the Core18 priority interrupt controller.
package int18_pkg;

   localparam int VEC_W = 4;

   localparam logic [1:0] REG_MASK = 2'd0;
   localparam logic [1:0] REG_PEND = 2'd1;
   localparam logic [1:0] REG_STAT = 2'd2;

   typedef enum logic [1:0] {
      IDLE,
      PRESENT,
      GAP
   } state_t;

   // Bits 1..num_irq set; request lines above num_irq are tied off.
   function automatic logic [15:1] irq_valid_mask(input int num_irq);
      logic [15:1] m;
      m = '0;
      for (int i = 1; i <= 15; i++) begin
         if (i <= num_irq) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/int18_prio_enc.sv
// Lowest-index-first priority encoder: 15 request bits to a 4-bit vector, 0 when empty.
module int18_prio_enc
   import int18_pkg::*;
(
   input  logic [15:1]      req,
   output logic [VEC_W-1:0] vec
);

   // Scan from the top so the lowest set index is the last one written.
   always_comb begin
      vec = '0;
      for (int i = 15; i >= 1; i--) begin
         if (req[i]) vec = VEC_W'(i);
      end
   end

endmodule

// File: rtl/int18_ctrl.sv
// Core18 priority interrupt controller: pending capture, MASK/PEND/STAT
// port registers and the vector presenter FSM.
// Build option INT18_EDGE_EN: defined = edge capture with W1C pending bits,
// undefined = level mode (pending mirrors IRQ directly).
//
// state   | meaning
// IDLE    | nothing presented, VECTOR=0
// PRESENT | VECTOR held until fetched or the source drops
// GAP     | one dead cycle after a fetch, VECTOR=0
module int18_ctrl
   import int18_pkg::*;
#(
   parameter int          NUM_IRQ = 15,
   parameter logic [17:0] BASE    = 18'o777700
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [15:1]      IRQ,
   input  logic [11:0]      PC,
   input  logic             RUN,
   input  logic [17:0]      ADRS,
   input  logic [17:0]      DATAOUT,
   input  logic             PORT_WR,
   input  logic             PORT_RD,
   output logic [17:0]      PORT_DATA,
   output logic [VEC_W-1:0] VECTOR
);

   localparam logic [15:1] IRQ_VALID = irq_valid_mask(NUM_IRQ);

   state_t            state_q, state_d;
   logic [VEC_W-1:0]  vector_q, vector_d, enc_vec;
   logic [15:1]       mask_q, pend, elig;
   logic [15:0]       elig_idx;
   logic              cur_elig, ack_hit;
   logic [17:0]       off;
   logic              hit, wr_mask;
   logic              unused_data;

   assign off     = ADRS - BASE;
   assign hit     = (ADRS >= BASE) && (off < 18'd3);
   assign wr_mask = PORT_WR && hit && (off[1:0] == REG_MASK);

   // Write-data bits outside [15:1] carry no register state.
   assign unused_data = ^{DATAOUT[17:16], DATAOUT[0]};

   // MASK register; a new value only affects eligibility from the next cycle.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) mask_q <= '0;
      else if (wr_mask) mask_q <= DATAOUT[15:1] & IRQ_VALID;
   end

`ifdef INT18_EDGE_EN
   logic [15:1] irq_q, pend_q, rise, w1c_clr, ack_clr;
   logic [15:0] ack_onehot;
   logic        ack_fire;
   logic        unused_ack0;

   assign ack_fire    = (state_q == PRESENT) && cur_elig && ack_hit;
   assign rise        = IRQ & ~irq_q & IRQ_VALID;
   assign w1c_clr     = (PORT_WR && hit && (off[1:0] == REG_PEND)) ? DATAOUT[15:1] : '0;
   assign ack_onehot  = {15'd0, ack_fire} << vector_q;
   assign ack_clr     = ack_onehot[15:1];
   assign unused_ack0 = ack_onehot[0];
   assign pend        = pend_q;

   // Edge capture; a new rising edge beats any clear aimed at the same bit.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         irq_q  <= '0;
         pend_q <= '0;
      end else begin
         irq_q  <= IRQ & IRQ_VALID;
         pend_q <= (pend_q & ~(w1c_clr | ack_clr)) | rise;
      end
   end
`else
   // Level mode: the device holds IRQ until serviced, so pending is the line itself.
   assign pend = IRQ & IRQ_VALID;
`endif

   assign elig     = pend & mask_q;
   assign elig_idx = {elig, 1'b0};
   assign cur_elig = elig_idx[vector_q];
   assign ack_hit  = RUN && (PC == {8'd0, vector_q});

   int18_prio_enc u_prio_enc (
      .req (elig),
      .vec (enc_vec)
   );

   // Presenter state and the registered VECTOR.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         vector_q <= '0;
      end else begin
         state_q  <= state_d;
         vector_q <= vector_d;
      end
   end

   // Next state; a source that has already dropped retracts even if fetched.
   always_comb begin
      state_d  = state_q;
      vector_d = vector_q;
      case (state_q)
         IDLE: begin
            vector_d = '0;
            if (|elig) begin
               vector_d = enc_vec;
               state_d  = PRESENT;
            end
         end
         PRESENT: begin
            if (!cur_elig) begin
               vector_d = '0;
               state_d  = IDLE;
            end else if (ack_hit) begin
               vector_d = '0;
               state_d  = GAP;
            end
         end
         GAP: begin
            vector_d = '0;
            state_d  = IDLE;
         end
         default: begin
            vector_d = '0;
            state_d  = IDLE;
         end
      endcase
   end

   // Same-cycle read mux; zero outside the register window or without PORT_RD.
   always_comb begin
      PORT_DATA = '0;
      if (PORT_RD && hit) begin
         case (off[1:0])
            REG_MASK: PORT_DATA = {2'b00, mask_q, 1'b0};
            REG_PEND: PORT_DATA = {2'b00, pend, 1'b0};
            REG_STAT: PORT_DATA = {14'd0, vector_q};
            default:  PORT_DATA = '0;
         endcase
      end
   end

   assign VECTOR = vector_q;

endmodule

// File: tb/tb_int18_ctrl.sv
// Directed scoreboard bench for int18_ctrl; follows the build mode of INT18_EDGE_EN.
module tb_int18_ctrl;

   localparam logic [17:0] BASE = 18'o777700;
`ifdef INT18_EDGE_EN
   localparam int   LAT       = 2;
   localparam logic EDGE_MODE = 1'b1;
`else
   localparam int   LAT       = 1;
   localparam logic EDGE_MODE = 1'b0;
`endif

   logic        CLK, RESET_N, RUN, PORT_WR, PORT_RD;
   logic [15:1] IRQ;
   logic [11:0] PC;
   logic [17:0] ADRS, DATAOUT, PORT_DATA;
   logic [3:0]  VECTOR;

   int n_checks = 0;
   int n_fail   = 0;
   string       tag_q[$];
   logic [17:0] val_q[$];

   int18_ctrl #(.NUM_IRQ(15), .BASE(BASE)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .IRQ(IRQ), .PC(PC), .RUN(RUN),
      .ADRS(ADRS), .DATAOUT(DATAOUT), .PORT_WR(PORT_WR), .PORT_RD(PORT_RD),
      .PORT_DATA(PORT_DATA), .VECTOR(VECTOR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [17:0] v);
      tag_q.push_back(tag);
      val_q.push_back(v);
   endtask

   task automatic compare(input logic [17:0] obs);
      string       t;
      logic [17:0] e;
      n_checks++;
      if (val_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=%0o expected=none", obs);
      end else begin
         t = tag_q.pop_front();
         e = val_q.pop_front();
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0o expected=%0o", t, obs, e);
         end
      end
   endtask

   task automatic step_vec(input string tag, input logic [3:0] e);
      expect_val(tag, {14'd0, e});
      tick();
      compare({14'd0, VECTOR});
   endtask

   task automatic rd_chk(input string tag, input logic [17:0] addr, input logic [17:0] e);
      expect_val(tag, e);
      ADRS    = addr;
      PORT_RD = 1'b1;
      #1;
      compare(PORT_DATA);
      PORT_RD = 1'b0;
      ADRS    = '0;
   endtask

   task automatic port_wr(input logic [17:0] addr, input logic [17:0] d);
      ADRS    = addr;
      DATAOUT = d;
      PORT_WR = 1'b1;
      tick();
      PORT_WR = 1'b0;
      DATAOUT = '0;
      ADRS    = '0;
   endtask

   task automatic pulse_end(input int b);
      if (EDGE_MODE) IRQ[b] = 1'b0;
   endtask

   task automatic fetch(input string tag, input logic [11:0] pc_v);
      PC  = pc_v;
      RUN = 1'b1;
      step_vec(tag, 4'd0);
      RUN = 1'b0;
      PC  = '0;
   endtask

   initial begin
      RESET_N = 1'b0; IRQ = '0; PC = '0; RUN = 1'b0;
      ADRS = '0; DATAOUT = '0; PORT_WR = 1'b0; PORT_RD = 1'b0;
      repeat (2) tick();
      expect_val("rst_vec", 18'd0);
      compare({14'd0, VECTOR});
      RESET_N = 1'b1;
      tick();
      rd_chk("rst_mask", BASE, 18'd0);
      rd_chk("rst_pend", BASE + 18'd1, 18'd0);
      rd_chk("rst_stat", BASE + 18'd2, 18'd0);

      // single source, decode, fetch and re-presentation after GAP
      port_wr(BASE, 18'o000040);
      rd_chk("t1_mask", BASE, 18'o000040);
      port_wr(BASE + 18'd3, 18'o177776);
      port_wr(BASE - 18'd1, 18'o177776);
      port_wr(BASE + 18'd2, 18'o177776);
      rd_chk("t1_mask_kept", BASE, 18'o000040);
      expect_val("t1_no_rd", 18'd0);
      ADRS = BASE;
      #1;
      compare(PORT_DATA);
      ADRS = '0;
      IRQ[5] = 1'b1;
      repeat (LAT - 1) tick();
      step_vec("t1_vec", 4'd5);
      rd_chk("t1_stat", BASE + 18'd2, 18'd5);
      pulse_end(5);
      fetch("t1_ack", 12'o0005);
      rd_chk("t1_pend_ack", BASE + 18'd1, EDGE_MODE ? 18'd0 : 18'o000040);
      IRQ[5] = 1'b1;
      step_vec("t1_gap", 4'd0);
      step_vec("t1_repres", 4'd5);
      pulse_end(5);
      port_wr(BASE, 18'd0);
      step_vec("t1_mask_retract", 4'd0);
      IRQ[5] = 1'b0;
      port_wr(BASE + 18'd1, 18'o000040);
      rd_chk("t1_pend_clr", BASE + 18'd1, 18'd0);

      // no preemption of a presented vector
      port_wr(BASE, 18'o177776);
      IRQ[9] = 1'b1;
      repeat (LAT - 1) tick();
      step_vec("t2_vec9", 4'd9);
      pulse_end(9);
      IRQ[2] = 1'b1;
      step_vec("t2_hold_a", 4'd9);
      step_vec("t2_hold_b", 4'd9);
      pulse_end(2);
      fetch("t2_ack9", 12'o0011);
      IRQ[9] = 1'b0;
      step_vec("t2_gap", 4'd0);
      step_vec("t2_vec2", 4'd2);
      fetch("t2_ack2", 12'o0002);
      IRQ[2] = 1'b0;
      repeat (2) tick();

      // extreme indices together: 1 first, then 15
      IRQ[15] = 1'b1;
      IRQ[1]  = 1'b1;
      repeat (LAT - 1) tick();
      step_vec("t6_vec1", 4'd1);
      pulse_end(1);
      pulse_end(15);
      fetch("t6_ack1", 12'o0001);
      IRQ[1] = 1'b0;
      step_vec("t6_gap", 4'd0);
      step_vec("t6_vec15", 4'd15);
      fetch("t6_ack15", 12'o0017);
      IRQ[15] = 1'b0;
      repeat (2) tick();

      // masked request stays pending, unmask presents it
      port_wr(BASE, 18'd0);
      IRQ[3] = 1'b1;
      repeat (LAT) tick();
      pulse_end(3);
      rd_chk("t3_pend", BASE + 18'd1, 18'o000010);
      expect_val("t3_vec_masked", 18'd0);
      compare({14'd0, VECTOR});
      expect_val("t3_vec_wr", 18'd0);
      port_wr(BASE, 18'o000010);
      compare({14'd0, VECTOR});
      step_vec("t3_vec3", 4'd3);
      fetch("t3_ack", 12'o0003);
      IRQ[3] = 1'b0;
      repeat (2) tick();

      // retraction before fetch
      port_wr(BASE, 18'o177776);
      IRQ[4] = 1'b1;
      repeat (LAT - 1) tick();
      step_vec("t4_vec4", 4'd4);
      pulse_end(4);
      port_wr(BASE + 18'd1, 18'o000020);
      rd_chk("t4_pend_w1c", BASE + 18'd1, EDGE_MODE ? 18'd0 : 18'o000020);
      IRQ[4] = 1'b0;
      step_vec("t4_retract", 4'd0);
      rd_chk("t4_stat", BASE + 18'd2, 18'd0);
      tick();

      // new edge and W1C on the same bit in one cycle
      IRQ[6] = 1'b1;
      port_wr(BASE + 18'd1, 18'o000100);
      rd_chk("t5_pend", BASE + 18'd1, 18'o000100);
      step_vec("t5_vec6", 4'd6);
      pulse_end(6);
      fetch("t5_ack", 12'o0006);
      IRQ[6] = 1'b0;
      repeat (2) tick();

      // asynchronous reset while presenting
      IRQ[7] = 1'b1;
      repeat (LAT - 1) tick();
      step_vec("t7_vec7", 4'd7);
      RESET_N = 1'b0;
      #1;
      expect_val("t7_rst_vec", 18'd0);
      compare({14'd0, VECTOR});
      IRQ = '0;
      tick();
      RESET_N = 1'b1;
      tick();
      rd_chk("t7_mask", BASE, 18'd0);
      rd_chk("t7_pend", BASE + 18'd1, 18'd0);
      port_wr(BASE, 18'o177776);
      rd_chk("t7_base3", BASE + 18'd3, 18'd0);
      rd_chk("t7_base_m1", BASE - 18'd1, 18'd0);
      rd_chk("t7_mask_back", BASE, 18'o177776);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
